// File: rtl/fetch_redirect.sv
// Instruction-fetch front end: sequential fetch with branch redirect, wrong-path
// squash and hazard discard, presenting one instruction at a time to decode.
module fetch_redirect #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        discard_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] pend_target;
    logic        squash;
    logic [31:0] target;

    assign target      = {branch_target_i[31:2], 2'b00};
    assign imem_addr_o = fetch_pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            fetch_pc      <= RESET_ADDR;
            squash        <= 1'b0;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= 32'd0;
            pc_o          <= RESET_ADDR;
        end else begin
            unique case (state)
                IDLE: begin
                    if (branch_i) begin
                        fetch_pc <= target;
                    end
                    imem_req_o <= 1'b1;
                    state      <= REQUEST;
                end
                REQUEST: begin
                    if (imem_ack_i) begin
                        // Wrong-path data is dropped; a same-cycle branch beats the pending target.
                        if (squash || branch_i) begin
                            fetch_pc <= branch_i ? target : pend_target;
                            squash   <= 1'b0;
                        end else begin
                            instr_o       <= imem_data_i;
                            pc_o          <= fetch_pc;
                            fetch_pc      <= fetch_pc + 32'd4;
                            instr_valid_o <= 1'b1;
                            imem_req_o    <= 1'b0;
                            state         <= HOLD;
                        end
                    end else if (branch_i) begin
                        squash <= 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_i || discard_i || instr_ready_i) begin
                        if (branch_i) begin
                            fetch_pc <= target;
                        end
                        instr_valid_o <= 1'b0;
                        imem_req_o    <= 1'b1;
                        state         <= REQUEST;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The address on the bus must not move until ack, so a redirect waits here.
    always_ff @(posedge clk_i) begin
        if (state == REQUEST && branch_i && !imem_ack_i) begin
            pend_target <= target;
        end
    end

endmodule

// File: tb/tb_fetch_redirect.sv
// Randomized bench for fetch_redirect: a program-flow model predicts the pc of
// each presented instruction; a negedge monitor pops and compares.
module tb_fetch_redirect;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        discard_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'd0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    int unsigned ack_pct  = 100;
    int unsigned rdy_pct  = 100;
    int unsigned br_pct   = 0;
    int unsigned disc_pct = 0;

    always #5 clk_i = ~clk_i;

    fetch_redirect #(.RESET_ADDR(RST_PC)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .discard_i      (discard_i),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_ack_i     (imem_ack_i),
        .imem_data_i    (imem_data_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .instr_ready_i  (instr_ready_i)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Drive one cycle of stimulus just after the rising edge.
    task automatic cycle();
        @(posedge clk_i);
        #1;
        if (imem_req_o && ($urandom_range(99) < ack_pct)) begin
            imem_ack_i  = 1'b1;
            imem_data_i = mem_word(imem_addr_o);
        end else begin
            imem_ack_i  = 1'b0;
            imem_data_i = $urandom();
        end
        branch_i        = ($urandom_range(99) < br_pct);
        branch_target_i = $urandom();
        discard_i       = ($urandom_range(99) < disc_pct);
        instr_ready_i   = ($urandom_range(99) < rdy_pct);
    endtask

    // Monitor / reference model
    logic        m_prev_valid = 1'b0;
    logic        m_prev_end   = 1'b0;
    logic        m_prev_req   = 1'b0;
    logic        m_prev_ack   = 1'b0;
    logic [31:0] m_prev_pc    = 32'd0;
    logic [31:0] m_prev_instr = 32'd0;
    logic [31:0] m_prev_addr  = 32'd0;
    logic [31:0] m_exp;
    int          m_wait = 0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            m_prev_valid = 1'b0;
            m_prev_end   = 1'b0;
            m_prev_req   = 1'b0;
            m_prev_ack   = 1'b0;
            m_wait       = 0;
        end else begin
            if (instr_valid_o && (!m_prev_valid || m_prev_end)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: pc %h presented, none expected", pc_o);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("present_pc", pc_o, m_exp);
                    check("present_instr", instr_o, mem_word(m_exp));
                end
                m_wait = 0;
            end else if (instr_valid_o) begin
                check("hold_pc_stable", pc_o, m_prev_pc);
                check("hold_instr_stable", instr_o, m_prev_instr);
            end else if (exp_q.size() != 0) begin
                m_wait++;
                if (m_wait > 200) begin
                    fail_now("output_timeout");
                    m_wait = 0;
                end
            end

            if (m_prev_req && !m_prev_ack && imem_req_o)
                check("addr_hold_until_ack", imem_addr_o, m_prev_addr);
            check_bit("single_outstanding", imem_req_o & instr_valid_o, 1'b0);

            // Next presentation predicted from program-flow rules
            m_prev_end = instr_valid_o && (branch_i || discard_i || instr_ready_i);
            if (branch_i) begin
                exp_q.delete();
                exp_q.push_back(branch_target_i & 32'hFFFF_FFFC);
            end else if (instr_valid_o && (discard_i || instr_ready_i)) begin
                exp_q.push_back(pc_o + 32'd4);
            end

            m_prev_valid = instr_valid_o;
            m_prev_req   = imem_req_o;
            m_prev_ack   = imem_ack_i;
            m_prev_pc    = pc_o;
            m_prev_instr = instr_o;
            m_prev_addr  = imem_addr_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic        prev_req;
        logic [31:0] rec_pc;
        logic [31:0] rec_instr;
        logic [31:0] rec_addr;

        // Reset values
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check_bit("rst_req", imem_req_o, 1'b0);
        check_bit("rst_valid", instr_valid_o, 1'b0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_pc", pc_o, RST_PC);
        check("rst_instr", instr_o, 32'd0);
        exp_q.push_back(RST_PC);
        rst_i = 1'b0;

        // Zero-wait memory, decode always ready
        ack_pct = 100; rdy_pct = 100;
        cycle();
        k = 0;
        while (!instr_valid_o && k < 20) begin cycle(); k++; end
        if (!instr_valid_o) fail_now("wait_first_valid");
        prev_req = imem_req_o;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_bit("req_alternate", imem_req_o, ~prev_req);
            prev_req = imem_req_o;
        end

        // Backpressure
        rdy_pct = 0;
        cycle();
        k = 0;
        while (!instr_valid_o && k < 20) begin cycle(); k++; end
        if (!instr_valid_o) fail_now("wait_bp_valid");
        rec_pc    = pc_o;
        rec_instr = instr_o;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_bit("bp_valid", instr_valid_o, 1'b1);
            check_bit("bp_req", imem_req_o, 1'b0);
            check("bp_pc", pc_o, rec_pc);
            check("bp_instr", instr_o, rec_instr);
        end
        rdy_pct = 100;
        repeat (6) cycle();

        // Branch while a request waits for ack
        ack_pct = 0;
        cycle();
        k = 0;
        while (!(imem_req_o && !instr_valid_o) && k < 20) begin cycle(); k++; end
        if (!(imem_req_o && !instr_valid_o)) fail_now("wait_request");
        rec_addr        = imem_addr_o;
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_2003;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_bit("squash_req_held", imem_req_o, 1'b1);
            check("squash_addr_held", imem_addr_o, rec_addr);
        end
        ack_pct = 100;
        cycle();
        check("squash_ack_addr", imem_addr_o, rec_addr);
        cycle();
        check_bit("redirect_req", imem_req_o, 1'b1);
        check("redirect_addr", imem_addr_o, 32'h0000_2000);
        check_bit("squashed_no_output", instr_valid_o, 1'b0);
        repeat (6) cycle();

        // Discard of a presented instruction
        rdy_pct = 0;
        cycle();
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_0200;
        cycle();
        k = 0;
        while (!(instr_valid_o && pc_o == 32'h0000_0200) && k < 20) begin cycle(); k++; end
        if (!(instr_valid_o && pc_o == 32'h0000_0200)) fail_now("wait_pc_200");
        discard_i = 1'b1;
        cycle();
        check_bit("discard_drops_valid", instr_valid_o, 1'b0);
        check_bit("discard_refetch_req", imem_req_o, 1'b1);
        check("discard_refetch_addr", imem_addr_o, 32'h0000_0204);
        rdy_pct = 100;
        repeat (6) cycle();

        // Address wrap
        cycle();
        branch_i        = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        repeat (12) cycle();

        // Randomized traffic
        ack_pct = 50; rdy_pct = 60; br_pct = 8; disc_pct = 8;
        repeat (3000) cycle();

        // Asynchronous reset in the middle of a request
        br_pct = 0; disc_pct = 0; ack_pct = 0; rdy_pct = 100;
        cycle();
        k = 0;
        while (!(imem_req_o && !instr_valid_o) && k < 20) begin cycle(); k++; end
        if (!(imem_req_o && !instr_valid_o)) fail_now("wait_request_for_reset");
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_bit("async_rst_req", imem_req_o, 1'b0);
        check_bit("async_rst_valid", instr_valid_o, 1'b0);
        check("async_rst_addr", imem_addr_o, RST_PC);
        check("async_rst_pc", pc_o, RST_PC);
        exp_q.delete();
        exp_q.push_back(RST_PC);
        repeat (2) @(negedge clk_i);
        #2;
        imem_ack_i  = 1'b1;
        imem_data_i = 32'hDEAD_BEEF;
        rst_i       = 1'b0;
        ack_pct     = 100;
        cycle();
        check_bit("restart_req", imem_req_o, 1'b1);
        check("restart_addr", imem_addr_o, RST_PC);
        repeat (10) cycle();

        br_pct = 0; disc_pct = 0; ack_pct = 100; rdy_pct = 100;
        repeat (4) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
